// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state codes shown on the board LEDs.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LOAD       = 3'd0,
        S_WRITE      = 3'd1,
        S_VERIFY_RD  = 3'd2,
        S_VERIFY_CMP = 3'd3,
        S_RELEASE    = 3'd4,
        S_RUN        = 3'd5
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer and a
// single-cycle press pulse on each accepted release-to-press transition.
module key_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the key, count samples that disagree with the accepted level, flip on a full run.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                press_r <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/program_loader.sv
// Loads switch-entered instruction words into instruction memory while holding the
// processor in reset. Optional readback check enabled by defining LOADER_VERIFY_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              key_commit,
    input  logic              key_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              proc_resetn,
    output logic              proc_run,
    output logic [ADDR_W:0]   word_count,
    output logic              load_full,
    output logic [2:0]        state,
    output logic              verify_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    logic commit_level_s, commit_press_s;
    logic done_level_s, done_press_s;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_commit_db (
        .Clock  (Clock),
        .Resetn (Resetn),
        .key_n  (key_commit),
        .level  (commit_level_s),
        .press  (commit_press_s)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_done_db (
        .Clock  (Clock),
        .Resetn (Resetn),
        .key_n  (key_done),
        .level  (done_level_s),
        .press  (done_press_s)
    );

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] data_r, data_n;
    logic [ADDR_W:0]   count_r, count_n;
    logic              wren_r;
    logic              run_r;
    logic              full_s;

    // word_count never exceeds 2**ADDR_W, so its top bit alone marks a full memory.
    assign full_s = count_r[ADDR_W];

    // Next-state and datapath updates for the load/write/release/run sequence.
    always_comb begin
        state_n = state_r;
        addr_n  = addr_r;
        data_n  = data_r;
        count_n = count_r;
        case (state_r)
            S_LOAD: begin
                if (done_press_s) begin
                    state_n = S_RELEASE;
                end else if (commit_press_s && !full_s) begin
                    data_n  = sw_data;
                    state_n = S_WRITE;
                end else begin
                    state_n = S_LOAD;
                end
            end
            S_WRITE: begin
                count_n = count_r + CNT_ONE;
`ifdef LOADER_VERIFY_EN
                state_n = S_VERIFY_RD;
`else
                addr_n  = addr_r + ADDR_ONE;
                state_n = S_LOAD;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY_RD: begin
                state_n = S_VERIFY_CMP;
            end
            S_VERIFY_CMP: begin
                addr_n  = addr_r + ADDR_ONE;
                state_n = S_LOAD;
            end
`endif
            S_RELEASE: begin
                state_n = S_RUN;
            end
            S_RUN: begin
                if (done_press_s) begin
                    addr_n  = '0;
                    count_n = '0;
                    state_n = S_LOAD;
                end else begin
                    state_n = S_RUN;
                end
            end
            default: begin
                state_n = S_LOAD;
            end
        endcase
    end

    // State and datapath registers; strobe and run outputs are registered from the next state.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_r <= S_LOAD;
            addr_r  <= '0;
            data_r  <= '0;
            count_r <= '0;
            wren_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            addr_r  <= addr_n;
            data_r  <= data_n;
            count_r <= count_n;
            wren_r  <= (state_n == S_WRITE);
            run_r   <= (state_n == S_RUN);
        end
    end

`ifdef LOADER_VERIFY_EN
    logic err_r;

    // Sticky readback mismatch flag, cleared only by reset or a new load session.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            err_r <= 1'b0;
        end else if ((state_r == S_RUN) && done_press_s) begin
            err_r <= 1'b0;
        end else if ((state_r == S_VERIFY_CMP) && (mem_q != data_r)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign verify_err = err_r;
`else
    logic unused_s;
    assign unused_s   = ^{mem_q, commit_level_s, done_level_s};
    assign verify_err = 1'b0;
`endif

`ifdef LOADER_VERIFY_EN
    logic unused_levels_s;
    assign unused_levels_s = commit_level_s ^ done_level_s;
`endif

    assign mem_addr    = addr_r;
    assign mem_data    = data_r;
    assign mem_wren    = wren_r;
    assign proc_resetn = run_r;
    assign proc_run    = run_r;
    assign word_count  = count_r;
    assign load_full   = full_s;
    assign state       = state_r;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (ADDR_W=2, DB_CYCLES=4); expected writes are
// queued by the stimulus and popped by a monitor on every mem_wren.
module tb_program_loader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 16;
    localparam int DB     = 4;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic [DATA_W-1:0] sw_data = '0;
    logic              key_commit = 1'b1;
    logic              key_done = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q = '0;
    logic              proc_resetn;
    logic              proc_run;
    logic [ADDR_W:0]   word_count;
    logic              load_full;
    logic [2:0]        state;
    logic              verify_err;

    always #5 Clock = ~Clock;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DB_CYCLES(DB)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .sw_data     (sw_data),
        .key_commit  (key_commit),
        .key_done    (key_done),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .proc_resetn (proc_resetn),
        .proc_run    (proc_run),
        .word_count  (word_count),
        .load_full   (load_full),
        .state       (state),
        .verify_err  (verify_err)
    );

    // Memory model with 1-cycle read latency; address 2 reads back corrupted.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge Clock) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= (mem_addr == 2'd2) ? (mem[mem_addr] ^ 16'h0100) : mem[mem_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic press_commit(input int hold);
        key_commit = 1'b0;
        cycles(hold);
        key_commit = 1'b1;
        cycles(12);
    endtask

    task automatic press_done();
        key_done = 1'b0;
        cycles(10);
        key_done = 1'b1;
        cycles(12);
    endtask

    task automatic monitor();
        wr_t got;
        wr_t exp;
        forever begin
            @(negedge Clock);
            if (mem_wren === 1'b1) begin
                got = '{a: mem_addr, d: mem_data};
                check("wren_in_write_state", 32'(state), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("write_addr_data", 32'(got), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        bit found;
        logic exp_err;
`ifdef LOADER_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        fork
            monitor();
        join_none

        cycles(3);
        @(negedge Clock);
        check("rst_state", 32'(state), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_proc", 32'({proc_resetn, proc_run, verify_err}), 32'd0);
        Resetn = 1'b1;
        cycles(3);

        // 1: single commit
        sw_data = 16'h1234;
        exp_q.push_back('{a: 2'd0, d: 16'h1234});
        press_commit(10);
        check("t1_count", 32'(word_count), 32'd1);
        check("t1_addr", 32'(mem_addr), 32'd1);

        // 2: long hold yields one write
        sw_data = 16'hABCD;
        exp_q.push_back('{a: 2'd1, d: 16'hABCD});
        press_commit(100);
        check("t2_count", 32'(word_count), 32'd2);

        // 3: short glitch is rejected
        sw_data = 16'hDEAD;
        press_commit(2);
        check("t3_count", 32'(word_count), 32'd2);

        // 4: fill to capacity, extra commit ignored
        sw_data = 16'h5555;
        exp_q.push_back('{a: 2'd2, d: 16'h5555});
        press_commit(10);
        sw_data = 16'h6666;
        exp_q.push_back('{a: 2'd3, d: 16'h6666});
        press_commit(10);
        check("t4_full", 32'(load_full), 32'd1);
        check("t4_count", 32'(word_count), 32'd4);
        check("t4_addr_wrap", 32'(mem_addr), 32'd0);
        sw_data = 16'h7777;
        press_commit(10);
        check("t4_ignored_count", 32'(word_count), 32'd4);
        check("t6_verify_err", 32'(verify_err), 32'(exp_err));

        // 5: simultaneous commit and done -> release, no write
        key_commit = 1'b0;
        key_done = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge Clock);
            if (state == 3'd4) found = 1'b1;
        end
        check("t5_release_seen", 32'(found), 32'd1);
        check("t5_release_proc", 32'({proc_resetn, proc_run}), 32'd0);
        @(negedge Clock);
        check("t5_run_state", 32'(state), 32'd5);
        check("t5_run_proc", 32'({proc_resetn, proc_run}), 32'd3);
        key_commit = 1'b1;
        key_done = 1'b1;
        cycles(12);
        check("t5_no_write_count", 32'(word_count), 32'd4);
        press_commit(10);
        check("t5_commit_in_run", 32'(state), 32'd5);
        press_done();
        check("t5_reload_state", 32'(state), 32'd0);
        check("t5_reload_addr", 32'(mem_addr), 32'd0);
        check("t5_reload_count", 32'(word_count), 32'd0);
        check("t5_reload_flags", 32'({proc_resetn, proc_run, verify_err}), 32'd0);

        // new session, then reset during a write
        sw_data = 16'h9999;
        exp_q.push_back('{a: 2'd0, d: 16'h9999});
        press_commit(10);
        check("s2_count", 32'(word_count), 32'd1);
        sw_data = 16'h8888;
        exp_q.push_back('{a: 2'd1, d: 16'h8888});
        key_commit = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge Clock);
            if (mem_wren === 1'b1) found = 1'b1;
        end
        check("abort_wren_seen", 32'(found), 32'd1);
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        check("abort_wren_off", 32'(mem_wren), 32'd0);
        check("abort_state", 32'({state, mem_addr}), 32'd0);
        check("abort_data", 32'(mem_data), 32'd0);
        key_commit = 1'b1;
        cycles(2);
        Resetn = 1'b1;
        cycles(12);
        check("abort_count", 32'(word_count), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
